// File: rtl/asu_pkg.sv
// Shared types and constants for the asu add/shift unit and its wide sequencer.
package asu_pkg;
  localparam int   BYTE_W   = 8;
  localparam logic MODE_ADD = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS_A = 2'd1,
    PASS_B = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/asu.sv
// 8-bit add/shift unit, combinational: mode 0 gives {carry,out} = x + y,
// mode 1 gives a left shift of x by one with the shifted-out bit on carry.
module asu
  import asu_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              mode,
  output logic [BYTE_W-1:0] out,
  output logic              carry
);
  always_comb begin
    if (mode == MODE_ADD) {carry, out} = {1'b0, x} + {1'b0, y};
    else                  {carry, out} = {x, 1'b0};
  end
endmodule

// File: rtl/asu_wide_ctrl.sv
// N-byte add/subtract sequenced through one 8-bit asu, two add passes per byte; done 2*NBYTES+1 cycles after start, start ignored unless idle.
// Define ASU_SKIP_ZERO_CIN_EN to skip the carry-in pass when the running carry is 0 (variable latency, same results).
module asu_wide_ctrl
  import asu_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     carry_out
);
  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t              state_q, state_d;
  logic [W-1:0]        a_q, b_q, result_q;
  logic [BYTE_W-1:0]   s_q, asu_x, asu_y, asu_out;
  logic                c1_q, cin_q, asu_carry;
  logic [IDX_W-1:0]    idx_q;
  logic                last_byte;

  assign last_byte = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = PASS_A;
      PASS_A: begin
`ifdef ASU_SKIP_ZERO_CIN_EN
        if (!cin_q) state_d = last_byte ? DONE : PASS_A;
        else        state_d = PASS_B;
`else
        state_d = PASS_B;
`endif
      end
      PASS_B: state_d = last_byte ? DONE : PASS_A;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // asu operands are muxed from registers only, keeping the path reg -> asu -> reg.
  always_comb begin
    busy  = (state_q == PASS_A) || (state_q == PASS_B);
    done  = (state_q == DONE);
    asu_x = a_q[idx_q*BYTE_W +: BYTE_W];
    asu_y = b_q[idx_q*BYTE_W +: BYTE_W];
    if (state_q == PASS_B) begin
      asu_x = s_q;
      asu_y = {{(BYTE_W-1){1'b0}}, cin_q};
    end
  end

  asu u_asu (
    .x     (asu_x),
    .y     (asu_y),
    .mode  (MODE_ADD),
    .out   (asu_out),
    .carry (asu_carry)
  );

  // Subtract is a + ~b + 1: the +1 enters as the initial running carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      s_q      <= '0;
      c1_q     <= 1'b0;
      cin_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= op_sub ? ~b : b;
          idx_q <= '0;
          cin_q <= op_sub;
        end
        PASS_A: begin
`ifdef ASU_SKIP_ZERO_CIN_EN
          if (!cin_q) begin
            result_q[idx_q*BYTE_W +: BYTE_W] <= asu_out;
            cin_q <= asu_carry;
            if (!last_byte) idx_q <= idx_q + IDX_W'(1);
          end else begin
            s_q  <= asu_out;
            c1_q <= asu_carry;
          end
`else
          s_q  <= asu_out;
          c1_q <= asu_carry;
`endif
        end
        PASS_B: begin
          result_q[idx_q*BYTE_W +: BYTE_W] <= asu_out;
          cin_q <= c1_q | asu_carry;
          if (!last_byte) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign carry_out = cin_q;
endmodule
